// File: rtl/tanh_fx_pkg.sv
`default_nettype none
// ============================================================================
// tanh_fx_pkg : fixed-point (x1e8) constants and segment codes for the PWL tanh
// Rev 1.0
// ============================================================================
package tanh_fx_pkg;

  localparam logic [32:0] SCALE  = 33'd100_000_000;
  localparam logic [32:0] BP_LIN = 33'd50_000_000;
  localparam logic [32:0] BP_MID = 33'd85_000_000;
  localparam logic [32:0] BP_HI  = SCALE;

  localparam logic [31:0] OFF_MID = 32'd25_000_000;
  localparam logic [31:0] OFF_HI  = 32'd70_000_000;

  typedef enum logic [1:0] {
    LIN = 2'd0,
    MID = 2'd1,
    HI  = 2'd2,
    SAT = 2'd3
  } seg_e;

  // 33-bit magnitude so that -2^31 yields +2^31 instead of wrapping
  function automatic logic [32:0] abs33(input logic [31:0] y);
    return y[31] ? (33'd0 - {1'b1, y}) : {1'b0, y};
  endfunction

endpackage
`default_nettype wire

// File: rtl/atanh_pwl_seg.sv
`default_nettype none
// ============================================================================
// atanh_pwl_seg : classifies |y| into the inverse-PWL segment
// Rev 1.0
// ============================================================================
module atanh_pwl_seg
  import tanh_fx_pkg::*;
(
  input  logic [32:0] abs_y,
  output seg_e        seg
);

  always_comb begin
    seg = SAT;
    if (abs_y <= BP_LIN)      seg = LIN;
    else if (abs_y <= BP_MID) seg = MID;
    else if (abs_y <= BP_HI)  seg = HI;
  end

endmodule
`default_nettype wire

// File: rtl/atanh_pwl.sv
`default_nettype none
// ============================================================================
// atanh_pwl : two-stage valid/ready inverse of the PWL tanh (x1e8 fixed point)
// Optional out_sat flag enabled by macro ATANH_PWL_SAT_FLAG_EN.  Rev 1.0
// ============================================================================
module atanh_pwl
  import tanh_fx_pkg::*;
#(
  parameter logic [31:0] OUT_SAT_POS = 32'h7FFF_FFFF,
  parameter logic [31:0] OUT_SAT_NEG = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_y,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef ATANH_PWL_SAT_FLAG_EN
  output logic               out_sat,
`endif
  output logic signed [31:0] out_x
);

  logic        rdy_en_q, rdy_en_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_neg_q, s1_neg_d;
  logic [31:0] s1_abs_q, s1_abs_d;
  seg_e        s1_seg_q, s1_seg_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_x_q, out_x_d;
`ifdef ATANH_PWL_SAT_FLAG_EN
  logic        out_sat_q, out_sat_d;
`endif

  logic [32:0] abs_in;
  seg_e        seg_in;
  logic        s2_adv, s1_adv, in_fire;
  logic [31:0] mag, res;

  assign abs_in = abs33(in_y);

  atanh_pwl_seg u_seg (
    .abs_y (abs_in),
    .seg   (seg_in)
  );

  // A stage may take new data when its slot is empty or its content leaves
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = rdy_en_q && s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    mag = s1_abs_q;
    case (s1_seg_q)
      LIN:     mag = s1_abs_q;
      MID:     mag = (s1_abs_q - OFF_MID) << 1;
      HI:      mag = (s1_abs_q - OFF_HI) << 3;
      default: mag = 32'd0;
    endcase
    res = s1_neg_q ? (32'd0 - mag) : mag;
    if (s1_seg_q == SAT) res = s1_neg_q ? OUT_SAT_NEG : OUT_SAT_POS;
  end

  always_comb begin
    rdy_en_d    = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_neg_d    = s1_neg_q;
    s1_abs_d    = s1_abs_q;
    s1_seg_d    = s1_seg_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
`ifdef ATANH_PWL_SAT_FLAG_EN
    out_sat_d   = out_sat_q;
`endif
    if (s1_adv) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_neg_d = in_y[31];
      s1_abs_d = abs_in[31:0];
      s1_seg_d = seg_in;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_x_d   = res;
`ifdef ATANH_PWL_SAT_FLAG_EN
        out_sat_d = (s1_seg_q == SAT);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_neg_q    <= 1'b0;
      s1_abs_q    <= 32'd0;
      s1_seg_q    <= LIN;
      out_valid_q <= 1'b0;
      out_x_q     <= 32'd0;
`ifdef ATANH_PWL_SAT_FLAG_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      rdy_en_q    <= rdy_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_neg_q    <= s1_neg_d;
      s1_abs_q    <= s1_abs_d;
      s1_seg_q    <= s1_seg_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
`ifdef ATANH_PWL_SAT_FLAG_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
`ifdef ATANH_PWL_SAT_FLAG_EN
  assign out_sat   = out_sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_atanh_pwl.sv
`default_nettype none
// ============================================================================
// tb_atanh_pwl : directed vectors plus scoreboard model of the inverse PWL tanh
// Rev 1.0
// ============================================================================
module tb_atanh_pwl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_y;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_x;
`ifdef ATANH_PWL_SAT_FLAG_EN
  logic               out_sat;
`endif

  atanh_pwl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ATANH_PWL_SAT_FLAG_EN
    .out_sat   (out_sat),
`endif
    .out_x     (out_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_x = 32'd0;

  function automatic exp_t model(input logic signed [31:0] y);
    exp_t   e;
    longint z, m;
    z = (y < 0) ? -longint'(y) : longint'(y);
    e.sat = (z > 64'sd100_000_000);
    if (z <= 64'sd50_000_000)      m = z;
    else if (z <= 64'sd85_000_000) m = 2 * (z - 64'sd25_000_000);
    else                           m = 8 * (z - 64'sd70_000_000);
    if (e.sat) e.x = (y < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       e.x = 32'((y < 0) ? -m : m);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard step: evaluated mid-cycle, describes the transfer at the next edge
  task automatic monitor();
    exp_t f;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_x", out_x, stall_x);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("stale_out", {31'd0, out_valid}, 32'd0);
      end else begin
        f = exp_q[0];
        chk("sb_x", out_x, f.x);
`ifdef ATANH_PWL_SAT_FLAG_EN
        chk("sb_sat", {31'd0, out_sat}, {31'd0, f.sat});
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_y));
    stall_prev = out_valid && !out_ready;
    stall_x    = out_x;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic signed [31:0] y, input logic [31:0] lit);
    in_valid  = 1'b1;
    in_y      = y;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, out_valid}, 32'd1);
    chk("dir_x", out_x, lit);
  endtask

  logic signed [31:0] dy [12] = '{
    32'sd30_000_000, 32'sd60_000_000, -32'sd90_000_000, 32'sd85_000_000,
    32'sd100_000_000, 32'sd100_000_001, -32'sd200_000_000, 32'sh8000_0000,
    32'sd0, 32'sd50_000_000, 32'sd50_000_001, -32'sd100_000_000};
  logic signed [31:0] dx [12] = '{
    32'sd30_000_000, 32'sd70_000_000, -32'sd160_000_000, 32'sd120_000_000,
    32'sd240_000_000, 32'sh7FFF_FFFF, 32'sh8000_0000, 32'sh8000_0000,
    32'sd0, 32'sd50_000_000, 32'sd50_000_002, -32'sd240_000_000};
  logic signed [31:0] sv [16] = '{
    32'sd10_000_000, -32'sd45_000_000, 32'sd55_000_000, -32'sd70_000_000,
    32'sd84_000_000, 32'sd86_000_000, -32'sd95_000_000, 32'sd99_000_000,
    32'sd101_000_000, -32'sd150_000_000, 32'sd0, 32'sd1,
    -32'sd1, 32'sd50_000_000, 32'sd85_000_001, -32'sd100_000_000};

  initial begin
    int   idx, cyc, base, cnt;
    logic fire, saw_low;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_y      = 32'sd0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_x", out_x, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < 12; k++) send_one(dy[k], dx[k]);
    tick();

    // back-to-back stream with a 4-cycle output stall
    base    = n_out;
    idx     = 0;
    cyc     = 0;
    saw_low = 1'b0;
    while (idx < 16 && cyc < 200) begin
      in_valid  = 1'b1;
      in_y      = sv[idx];
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      fire = in_ready;
      if (!in_ready) saw_low = 1'b1;
      tick();
      if (fire) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", idx, 32'd16);
    chk("stream_ready_drop", {31'd0, saw_low}, 32'd1);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("stream_drain", exp_q.size(), 32'd0);
    chk("stream_outputs", n_out - base, 32'd16);

    // reset with two samples in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_y      = 32'sd60_000_000;
    tick();
    in_y = -32'sd90_000_000;
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrel_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      tick();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    send_one(32'sd30_000_000, 32'd30_000_000);
    repeat (3) tick();
    chk("final_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atanh_pwl.md
ATANH_PWL -- requirements
Module: atanh_pwl

Interface
- REQ-001 Parameter: OUT_SAT_POS, 32'h7FFF_FFFF, result for inputs above +1.0 (scaled).
- REQ-002 Parameter: OUT_SAT_NEG, 32'h8000_0000, result for inputs below -1.0 (scaled).
- REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-004 rst_n  input  1  synchronous, active-low reset.
- REQ-005 in_valid  input  1  in_y holds a sample.
- REQ-006 in_ready  output  1  block accepts a sample this cycle.
- REQ-007 in_y  input  32 signed  tanh-domain value, fixed point scaled by 10^8.
- REQ-008 out_valid  output  1  out_x holds a result.
- REQ-009 out_ready  input  1  consumer accepts the result this cycle.
- REQ-010 out_x  output  32 signed  inverse value, scaled by 10^8.

Function
- REQ-011 The block SHALL compute the exact inverse of the team's piecewise-linear tanh: z=|in_y|; z<=50_000_000 -> x=in_y; 50_000_000<z<=85_000_000 -> |x|=2*(z-25_000_000); 85_000_000<z<=100_000_000 -> |x|=8*(z-70_000_000); z>100_000_000 -> OUT_SAT_POS/OUT_SAT_NEG per sign.
- REQ-012 Result sign SHALL equal sign of in_y; in_y=0 -> 0.
- REQ-013 |in_y| SHALL be computed in 33 bits so in_y=32'h8000_0000 classifies as saturated negative.
- REQ-014 Breakpoints SHALL be continuous: 85_000_000 -> 120_000_000, 100_000_000 -> 240_000_000; no intermediate overflows 32 bits.
- REQ-015 A sample SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
- REQ-016 Pipeline SHALL be two stages: S1 registers sign, |in_y| and segment code {LIN, MID, HI, SAT}; S2 registers out_x.
- REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high.
- REQ-018 Throughput SHALL be one sample per cycle under no backpressure.
- REQ-019 in_ready SHALL equal !(S1 valid && S2 valid && !out_ready); each stage advances when its downstream slot is empty or draining.
- REQ-020 out_x and out_valid SHALL hold stable while out_valid && !out_ready.
- REQ-021 Simultaneous input and output transfer on a full pipeline SHALL lose and duplicate no sample; order SHALL be preserved.
- REQ-022 No combinational path SHALL exist from in_valid/in_y to out_*; out_ready -> in_ready is permitted.

Reset
- REQ-023 While rst_n=0 at a clock edge: both stage valids 0, out_valid=0, out_x=0, in_ready=0.
- REQ-024 in_ready SHALL rise the first cycle after rst_n returns high.
- REQ-025 Reset mid-stream SHALL discard all in-flight samples; none SHALL emerge afterwards.

Configuration
- REQ-026 Macro ATANH_PWL_SAT_FLAG_EN: when defined, output out_sat (1 bit) SHALL be added, aligned with out_x, high iff the sample hit the SAT segment, reset 0.
- REQ-027 When ATANH_PWL_SAT_FLAG_EN is undefined, out_sat and its pipeline bits SHALL be absent; all else identical.

Structure
- REQ-028 Package tanh_fx_pkg SHALL hold SCALE=100_000_000, breakpoints 50_000_000, 85_000_000, 100_000_000, offsets 25_000_000, 70_000_000, and segment enum seg_e {LIN, MID, HI, SAT}.
- REQ-029 Combinational sub-module atanh_pwl_seg SHALL map |y| to seg_e; atanh_pwl instantiates it once in S1.
- REQ-030 Multiplies by 2 and 8 SHALL be shifts; no divider or multiplier.

Verification
- REQ-031 in_y=30_000_000 -> out_x=30_000_000 two cycles later.
- REQ-032 in_y=60_000_000 -> 70_000_000; in_y=-90_000_000 -> -160_000_000; in_y=85_000_000 -> 120_000_000.
- REQ-033 in_y=100_000_000 -> 240_000_000; 100_000_001 -> 32'h7FFF_FFFF; -200_000_000 and 32'h8000_0000 -> 32'h8000_0000 (out_sat=1 when enabled).
- REQ-034 Back-to-back stream of 16 samples with out_ready low 4 cycles mid-stream -> in_ready drops after pipeline fills, all 16 outputs correct and in order, out_x stable while stalled.
- REQ-035 rst_n low for one cycle with 2 samples in flight -> out_valid=0 next cycle, no stale output afterwards; next sample has 2-cycle latency.
